// File: rtl/rbuf_lanes.sv
// rbuf_lanes
// ----------
// Multi-lane activation ring buffer. LANES parallel lanes of WORDLEN-bit
// words share one write pointer, one read pointer and one occupancy
// counter. It reports full/empty/count status and sticky overflow and
// underflow flags, and accepts a synchronous flush. With SKEW=1, lane k's
// read data leaves k cycles after lane 0's, so rows can feed the west edge
// of a systolic array directly.
//
// Ports
//   clk     rising-edge clock
//   rstn    asynchronous active-low reset
//   clr     synchronous flush (wins over read/write)
//   write   push request, din sampled when accepted
//   read    pop request
//   din     write data, lane k at [k*WORDLEN +: WORDLEN]
//   dout    read data, same lane packing; each lane holds its last valid word
//   dvalid  per-lane valid strobe for dout
//   full    count == BUFSIZE (registered)
//   empty   count == 0 (registered)
//   count   current occupancy (registered)
//   ovf     sticky: a write was dropped
//   udf     sticky: a read hit an empty buffer
module rbuf_lanes #(
  parameter int WORDLEN = 8,
  parameter int BUFSIZE = 16,
  parameter int LANES   = 4,
  parameter int SKEW    = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       clr,
  input  logic                       write,
  input  logic                       read,
  input  logic [LANES*WORDLEN-1:0]   din,
  output logic [LANES*WORDLEN-1:0]   dout,
  output logic [LANES-1:0]           dvalid,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(BUFSIZE):0]   count,
  output logic                       ovf,
  output logic                       udf
);

  localparam int PW = $clog2(BUFSIZE);
  localparam int CW = PW + 1;

  logic [PW-1:0] wptr_r;
  logic [PW-1:0] rptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic          full_r;
  logic          empty_r;
  logic          ovf_r;
  logic          udf_r;
  logic          rd_ok_s;
  logic          wr_ok_s;

  // Accept decisions and next occupancy; a full buffer takes a write only
  // when a read frees a slot in the same cycle.
  always_comb begin
    rd_ok_s     = read && !empty_r;
    wr_ok_s     = write && (!full_r || rd_ok_s);
    count_nxt_s = count_r;
    if (wr_ok_s && !rd_ok_s) begin
      count_nxt_s = count_r + CW'(1);
    end else if (rd_ok_s && !wr_ok_s) begin
      count_nxt_s = count_r - CW'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Shared pointers, occupancy, status and sticky error flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
    end else if (clr) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wptr_r <= wptr_r + PW'(1);
      end
      if (rd_ok_s) begin
        rptr_r <= rptr_r + PW'(1);
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CW'(BUFSIZE));
      empty_r <= (count_nxt_s == CW'(0));
      ovf_r   <= ovf_r | (write & ~wr_ok_s);
      udf_r   <= udf_r | (read & empty_r);
    end
  end

  assign full  = full_r;
  assign empty = empty_r;
  assign count = count_r;
  assign ovf   = ovf_r;
  assign udf   = udf_r;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [WORDLEN-1:0] mem_r [BUFSIZE];
    logic [WORDLEN-1:0] rd_data_s;
    logic               tap_vld_s;
    logic [WORDLEN-1:0] tap_data_s;
    logic [WORDLEN-1:0] dout_r;
    logic               dvalid_r;

    // Lane storage; contents survive a flush, only the pointers move.
    always_ff @(posedge clk) begin
      if (wr_ok_s && !clr) begin
        mem_r[wptr_r] <= din[k*WORDLEN +: WORDLEN];
      end
    end

    assign rd_data_s = mem_r[rptr_r];

    if (SKEW != 0 && k > 0) begin : g_skew
      logic [k-1:0]       vld_r;
      logic [WORDLEN-1:0] dat_r [k];

      // k-deep delay line ahead of the output register; a flush kills
      // every in-flight valid at the same edge.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          vld_r <= '0;
          for (int j = 0; j < k; j++) begin
            dat_r[j] <= '0;
          end
        end else if (clr) begin
          vld_r <= '0;
        end else begin
          vld_r[0] <= rd_ok_s;
          dat_r[0] <= rd_data_s;
          for (int j = 1; j < k; j++) begin
            vld_r[j] <= vld_r[j-1];
            dat_r[j] <= dat_r[j-1];
          end
        end
      end

      assign tap_vld_s  = vld_r[k-1];
      assign tap_data_s = dat_r[k-1];
    end else begin : g_direct
      assign tap_vld_s  = rd_ok_s;
      assign tap_data_s = rd_data_s;
    end

    // Output register: data only updates on a valid, so each lane holds
    // its last word between bursts and across a flush.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        dout_r   <= '0;
        dvalid_r <= 1'b0;
      end else if (clr) begin
        dvalid_r <= 1'b0;
      end else begin
        dvalid_r <= tap_vld_s;
        if (tap_vld_s) begin
          dout_r <= tap_data_s;
        end
      end
    end

    assign dout[k*WORDLEN +: WORDLEN] = dout_r;
    assign dvalid[k]                  = dvalid_r;
  end

endmodule

// File: tb/tb_rbuf_lanes.sv
// Self-checking bench for rbuf_lanes: instance a uses SKEW=1, instance b
// uses SKEW=0; both share clock and request inputs but have separate resets.
module tb_rbuf_lanes;

  logic        clk = 1'b0;
  logic        rstn_a, rstn_b;
  logic        clr, write, read;
  logic [31:0] din;
  logic [31:0] dout_a, dout_b;
  logic [3:0]  dvalid_a, dvalid_b;
  logic        full_a, full_b, empty_a, empty_b;
  logic [4:0]  count_a, count_b;
  logic        ovf_a, ovf_b, udf_a, udf_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rbuf_lanes #(.WORDLEN(8), .BUFSIZE(16), .LANES(4), .SKEW(1)) u_a (
    .clk(clk), .rstn(rstn_a), .clr(clr), .write(write), .read(read),
    .din(din), .dout(dout_a), .dvalid(dvalid_a), .full(full_a),
    .empty(empty_a), .count(count_a), .ovf(ovf_a), .udf(udf_a));

  rbuf_lanes #(.WORDLEN(8), .BUFSIZE(16), .LANES(4), .SKEW(0)) u_b (
    .clk(clk), .rstn(rstn_b), .clr(clr), .write(write), .read(read),
    .din(din), .dout(dout_b), .dvalid(dvalid_b), .full(full_b),
    .empty(empty_b), .count(count_b), .ovf(ovf_b), .udf(udf_b));

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] din;
    logic [31:0] dout_a;
    logic [3:0]  dv_a;
    logic [31:0] dout_b;
    logic [3:0]  dv_b;
    logic [4:0]  cnt;
    logic        emp;
  } vec_t;

  vec_t tv[12];

  // expected-timing history for instance a (accepted read word per edge)
  int         hist[$];
  logic [7:0] hold[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] wd(input int idx, input int k);
    return 8'(k * 64 + idx);
  endfunction

  function automatic logic [31:0] row(input int idx);
    logic [31:0] r;
    r = 32'h0;
    for (int k = 0; k < 4; k++) r[k*8 +: 8] = wd(idx, k);
    return r;
  endfunction

  task automatic drv(input logic c, input logic w, input logic r, input logic [31:0] d);
    @(negedge clk);
    clr = c; write = w; read = r; din = d;
    @(posedge clk);
    #1;
  endtask

  // one cycle on instance a, checking every lane against the skew timing
  task automatic step(input logic c, input logic w, input logic r, input int wr_idx, input int rd_idx);
    int idx;
    drv(c, w, r, (wr_idx >= 0) ? row(wr_idx) : 32'h0);
    if (c) hist.delete();
    hist.push_back(c ? -1 : rd_idx);
    for (int k = 0; k < 4; k++) begin
      idx = (hist.size() > k) ? hist[hist.size() - 1 - k] : -1;
      if (idx >= 0) hold[k] = wd(idx, k);
      chk($sformatf("dvalid_a[%0d]", k), {31'h0, dvalid_a[k]}, (idx >= 0) ? 32'h1 : 32'h0);
      chk($sformatf("dout_a[%0d]", k), {24'h0, dout_a[k*8 +: 8]}, {24'h0, hold[k]});
    end
  endtask

  task automatic status_a(input string nm, input int cnt, input logic f, input logic e, input logic o, input logic u);
    chk({nm, " count"}, {27'h0, count_a}, 32'(cnt));
    chk({nm, " full"},  {31'h0, full_a},  {31'h0, f});
    chk({nm, " empty"}, {31'h0, empty_a}, {31'h0, e});
    chk({nm, " ovf"},   {31'h0, ovf_a},   {31'h0, o});
    chk({nm, " udf"},   {31'h0, udf_a},   {31'h0, u});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // scenario 1: 4 writes (lane k = 16*i+k) then 4 reads, then drain
    tv[0]  = '{1'b1, 1'b0, 32'h03020100, 32'h00000000, 4'h0, 32'h00000000, 4'h0, 5'd1, 1'b0};
    tv[1]  = '{1'b1, 1'b0, 32'h13121110, 32'h00000000, 4'h0, 32'h00000000, 4'h0, 5'd2, 1'b0};
    tv[2]  = '{1'b1, 1'b0, 32'h23222120, 32'h00000000, 4'h0, 32'h00000000, 4'h0, 5'd3, 1'b0};
    tv[3]  = '{1'b1, 1'b0, 32'h33323130, 32'h00000000, 4'h0, 32'h00000000, 4'h0, 5'd4, 1'b0};
    tv[4]  = '{1'b0, 1'b1, 32'h0,        32'h00000000, 4'h1, 32'h03020100, 4'hf, 5'd3, 1'b0};
    tv[5]  = '{1'b0, 1'b1, 32'h0,        32'h00000110, 4'h3, 32'h13121110, 4'hf, 5'd2, 1'b0};
    tv[6]  = '{1'b0, 1'b1, 32'h0,        32'h00021120, 4'h7, 32'h23222120, 4'hf, 5'd1, 1'b0};
    tv[7]  = '{1'b0, 1'b1, 32'h0,        32'h03122130, 4'hf, 32'h33323130, 4'hf, 5'd0, 1'b1};
    tv[8]  = '{1'b0, 1'b0, 32'h0,        32'h13223130, 4'he, 32'h33323130, 4'h0, 5'd0, 1'b1};
    tv[9]  = '{1'b0, 1'b0, 32'h0,        32'h23323130, 4'hc, 32'h33323130, 4'h0, 5'd0, 1'b1};
    tv[10] = '{1'b0, 1'b0, 32'h0,        32'h33323130, 4'h8, 32'h33323130, 4'h0, 5'd0, 1'b1};
    tv[11] = '{1'b0, 1'b0, 32'h0,        32'h33323130, 4'h0, 32'h33323130, 4'h0, 5'd0, 1'b1};

    rstn_a = 1'b0; rstn_b = 1'b0; clr = 1'b0; write = 1'b0; read = 1'b0; din = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst dout",   dout_a,            32'h0);
    chk("rst dvalid", {28'h0, dvalid_a}, 32'h0);
    status_a("rst", 0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rstn_a = 1'b1; rstn_b = 1'b1;

    for (int v = 0; v < 12; v++) begin
      drv(1'b0, tv[v].wr, tv[v].rd, tv[v].din);
      chk($sformatf("v%0d dout_a", v),   dout_a,            tv[v].dout_a);
      chk($sformatf("v%0d dvalid_a", v), {28'h0, dvalid_a}, {28'h0, tv[v].dv_a});
      chk($sformatf("v%0d dout_b", v),   dout_b,            tv[v].dout_b);
      chk($sformatf("v%0d dvalid_b", v), {28'h0, dvalid_b}, {28'h0, tv[v].dv_b});
      status_a($sformatf("v%0d", v), int'(tv[v].cnt), 1'b0, tv[v].emp, 1'b0, 1'b0);
    end

    for (int k = 0; k < 4; k++) hold[k] = 8'(48 + k);
    hist.delete();

    // scenario 2: fill, overflow, drain with pointer wrap
    for (int w = 0; w < 16; w++) step(1'b0, 1'b1, 1'b0, w, -1);
    status_a("fill", 16, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16, -1);
    status_a("ovf write", 16, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int j = 0; j < 16; j++) step(1'b0, 1'b0, 1'b1, -1, j);
    for (int j = 0; j < 3; j++) step(1'b0, 1'b0, 1'b0, -1, -1);
    status_a("drain", 0, 1'b0, 1'b1, 1'b1, 1'b0);

    // scenario 3: full buffer, simultaneous read+write
    step(1'b1, 1'b0, 1'b0, -1, -1);
    status_a("clr ovf", 0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int w = 20; w < 36; w++) step(1'b0, 1'b1, 1'b0, w, -1);
    for (int j = 0; j < 8; j++) begin
      step(1'b0, 1'b1, 1'b1, 36 + j, 20 + j);
      status_a("rw full", 16, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    for (int j = 28; j < 44; j++) step(1'b0, 1'b0, 1'b1, -1, j);
    for (int j = 0; j < 3; j++) step(1'b0, 1'b0, 1'b0, -1, -1);
    status_a("rw drain", 0, 1'b0, 1'b1, 1'b0, 1'b0);

    // scenario 4: read+write on empty, no bypass
    step(1'b0, 1'b1, 1'b1, 50, -1);
    status_a("empty rw", 1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, -1, 50);
    for (int j = 0; j < 3; j++) step(1'b0, 1'b0, 1'b0, -1, -1);
    status_a("empty rw drain", 0, 1'b0, 1'b1, 1'b0, 1'b1);

    // scenario 5: flush after 3 of 6 reads
    for (int w = 60; w < 66; w++) step(1'b0, 1'b1, 1'b0, w, -1);
    for (int j = 60; j < 63; j++) step(1'b0, 1'b0, 1'b1, -1, j);
    step(1'b1, 1'b0, 1'b1, -1, -1);
    status_a("flush", 0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) step(1'b0, 1'b0, 1'b0, -1, -1);
    step(1'b0, 1'b1, 1'b0, 70, -1);
    step(1'b0, 1'b0, 1'b1, -1, 70);
    for (int j = 0; j < 3; j++) step(1'b0, 1'b0, 1'b0, -1, -1);
    status_a("post flush", 0, 1'b0, 1'b1, 1'b0, 1'b0);

    // scenario 6: aligned lanes, async reset mid-burst
    drv(1'b1, 1'b0, 1'b0, 32'h0);
    drv(1'b0, 1'b1, 1'b0, 32'h03020100);
    drv(1'b0, 1'b1, 1'b0, 32'h13121110);
    drv(1'b0, 1'b1, 1'b0, 32'h23222120);
    drv(1'b0, 1'b1, 1'b0, 32'h33323130);
    drv(1'b0, 1'b0, 1'b1, 32'h0);
    chk("ns rd0 dout",   dout_b,            32'h03020100);
    chk("ns rd0 dvalid", {28'h0, dvalid_b}, 32'hf);
    drv(1'b0, 1'b0, 1'b1, 32'h0);
    chk("ns rd1 dout",   dout_b,            32'h13121110);
    chk("ns rd1 dvalid", {28'h0, dvalid_b}, 32'hf);
    chk("ns rd1 count",  {27'h0, count_b},  32'd2);
    #2;
    rstn_a = 1'b0; rstn_b = 1'b0;
    #1;
    chk("arst dout_b",   dout_b,            32'h0);
    chk("arst dvalid_b", {28'h0, dvalid_b}, 32'h0);
    chk("arst count_b",  {27'h0, count_b},  32'h0);
    chk("arst empty_b",  {31'h0, empty_b},  32'h1);
    chk("arst full_b",   {31'h0, full_b},   32'h0);
    chk("arst dout_a",   dout_a,            32'h0);
    chk("arst dvalid_a", {28'h0, dvalid_a}, 32'h0);
    status_a("arst", 0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    read = 1'b0;
    rstn_a = 1'b1; rstn_b = 1'b1;
    drv(1'b0, 1'b0, 1'b0, 32'h0);
    chk("post rst dvalid_a", {28'h0, dvalid_a}, 32'h0);
    chk("post rst dvalid_b", {28'h0, dvalid_b}, 32'h0);
    drv(1'b0, 1'b0, 1'b1, 32'h0);
    chk("post rst udf_b",    {31'h0, udf_b},    32'h1);
    chk("post rst rd dv_b",  {28'h0, dvalid_b}, 32'h0);
    chk("post rst empty_b",  {31'h0, empty_b},  32'h1);
    drv(1'b0, 1'b0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
